rtype_sequencer: RTL

RTYPE_SEQUENCER -- requirements
Module: rtype_sequencer

---
 rtl/rtype_sequencer_pkg.sv | 41 ++++
 rtl/rtype_sequencer_if.sv | 13 +
 rtl/rtype_sequencer_alu.sv | 34 +++
 rtl/rtype_sequencer.sv | 90 +++++++++
 4 files changed

// File: rtl/rtype_sequencer_pkg.sv
// Shared definitions for the R-type sequencer: FSM states, ALU function codes
// and the bit positions of the instruction fields.
package rtype_sequencer_pkg;

    localparam int INSTR_W  = 32;
    localparam int OPC_LSB  = 26;
    localparam int OPC_W    = 6;
    localparam int RS_LSB   = 22;
    localparam int RT_LSB   = 18;
    localparam int RD_LSB   = 14;
    localparam int REG_W    = 4;
    localparam int FUNC_LSB = 0;
    localparam int FUNC_W   = 4;

    localparam logic [FUNC_W-1:0] FUNC_ADD = 4'd0;
    localparam logic [FUNC_W-1:0] FUNC_SUB = 4'd1;
    localparam logic [FUNC_W-1:0] FUNC_AND = 4'd2;
    localparam logic [FUNC_W-1:0] FUNC_OR  = 4'd3;
    localparam logic [FUNC_W-1:0] FUNC_XOR = 4'd4;
    localparam logic [FUNC_W-1:0] FUNC_NOR = 4'd5;
    localparam logic [FUNC_W-1:0] FUNC_SLT = 4'd6;
    localparam logic [FUNC_W-1:0] FUNC_SLL = 4'd7;
    localparam logic [FUNC_W-1:0] FUNC_SRL = 4'd8;
    localparam logic [FUNC_W-1:0] FUNC_SRA = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WRITE,
        ERR
    } state_t;

    typedef struct packed {
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [FUNC_W-1:0] func;
    } fields_t;

endpackage

// File: rtl/rtype_sequencer_if.sv
// Instruction handshake between an instruction source (master) and the
// sequencer (slave).
interface rtype_sequencer_if;
    import rtype_sequencer_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/rtype_sequencer_alu.sv
// Combinational R-type ALU; shifts use only the low five bits of operand b.
module rtype_alu
    import rtype_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [FUNC_W-1:0] func,
    output logic [DATA_W-1:0] result
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (func)
            FUNC_ADD: result = a + b;
            FUNC_SUB: result = a - b;
            FUNC_AND: result = a & b;
            FUNC_OR:  result = a | b;
            FUNC_XOR: result = a ^ b;
            FUNC_NOR: result = ~(a | b);
            FUNC_SLT: result = DATA_W'($signed(a) < $signed(b));
            FUNC_SLL: result = a << shamt;
            FUNC_SRL: result = a >> shamt;
            FUNC_SRA: result = DATA_W'($signed(a) >>> shamt);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rtype_sequencer.sv
// Four-cycle R-type instruction sequencer: accept, read operands, execute,
// write back to an external register file.
module rtype_sequencer
    import rtype_sequencer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    rtype_sequencer_if.slave    bus,
    output logic [RADDR_W-1:0]  rf_rs,
    output logic [RADDR_W-1:0]  rf_rt,
    input  logic [DATA_W-1:0]   rf_rd1,
    input  logic [DATA_W-1:0]   rf_rd2,
    output logic [RADDR_W-1:0]  rf_rd,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                rf_write,
    output logic                done,
    output logic                err
);

    state_t            state_q, state_d;
    fields_t           fields_q, fields_in;
    logic [OPC_W-1:0]  opcode_in;
    logic              legal_in;
    logic [DATA_W-1:0] op_a, op_b, result_q, alu_result;
    logic              unused_bits;

    assign opcode_in      = bus.instr[OPC_LSB +: OPC_W];
    assign fields_in.rs   = bus.instr[RS_LSB +: REG_W];
    assign fields_in.rt   = bus.instr[RT_LSB +: REG_W];
    assign fields_in.rd   = bus.instr[RD_LSB +: REG_W];
    assign fields_in.func = bus.instr[FUNC_LSB +: FUNC_W];
    assign legal_in       = (opcode_in == '0) && (fields_in.func <= FUNC_SRA);
    assign unused_bits    = ^bus.instr[RD_LSB-1 : FUNC_LSB+FUNC_W];

    // Reset abandons any in-flight instruction; all datapath state is cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            fields_q <= '0;
            op_a     <= '0;
            op_b     <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.instr_valid) begin
                fields_q <= fields_in;
            end
            if (state_q == READ) begin
                op_a <= rf_rd1;
                op_b <= rf_rd2;
            end
            if (state_q == EXEC) begin
                result_q <= alu_result;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.instr_valid) state_d = legal_in ? READ : ERR;
            READ:    state_d = EXEC;
            EXEC:    state_d = WRITE;
            WRITE:   state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Addresses read as zero while idle so a stale instruction never leaks out.
    assign bus.instr_ready = (state_q == IDLE);
    assign rf_rs    = (state_q == IDLE) ? '0 : RADDR_W'(fields_q.rs);
    assign rf_rt    = (state_q == IDLE) ? '0 : RADDR_W'(fields_q.rt);
    assign rf_rd    = (state_q == IDLE) ? '0 : RADDR_W'(fields_q.rd);
    assign rf_wdata = result_q;
    assign rf_write = (state_q == WRITE);
    assign done     = (state_q == WRITE);
    assign err      = (state_q == ERR);

    rtype_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .func   (fields_q.func),
        .result (alu_result)
    );

endmodule
